// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [31:0] data_bus_t;

  // addi x0, x0, 0: the canonical bubble presented to decode
  localparam instruction_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    instruction_t inst;
    data_bus_t    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries; flush wins over a same-cycle push.
module instruction_fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // The request credit rule must make this unreachable
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: issues imem requests under a credit limit, buffers responses, feeds decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  jump_addr,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output instruction_t inst_id,
  output data_bus_t    pc_id,
  output logic         inst_valid_id
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    fetch_pc;
  logic [31:0]    rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  drop_cnt;
  logic [FCW-1:0] fifo_count;
  logic           fifo_empty;
  fetch_entry_t   fifo_head;
  fetch_entry_t   fifo_din;
  logic           transfer;
  logic           redirect;
  logic           rsp_push;
  logic           rsp_drop;
  logic           fifo_pop;
  logic           credit_ok;

  // Every granted request reserves a FIFO slot until its word has been consumed
  assign credit_ok = (int'(fifo_count) + int'(outstanding)) < FIFO_DEPTH;
  assign imem_req  = !rst && clk_en && !branch_taken &&
                     (int'(outstanding) < MAX_OUTSTANDING) && credit_ok;
  assign imem_addr = fetch_pc;
  assign transfer  = imem_req && imem_gnt;
  assign redirect  = clk_en && branch_taken;
  assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push  = imem_rsp_valid && (drop_cnt == '0);
  assign fifo_pop  = clk_en && !branch_taken && !stall && !fifo_empty;
  assign fifo_din  = '{inst: imem_rsp_data, pc: rsp_pc};

  instruction_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(transfer) - CW'(imem_rsp_valid);
      if (redirect) begin
        // Whatever is still in flight after this edge belongs to the wrong path
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
        fetch_pc <= {jump_addr[31:2], 2'b00};
        rsp_pc   <= {jump_addr[31:2], 2'b00};
      end else begin
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (transfer) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_push) rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_id       <= NOP_INST;
      pc_id         <= '0;
      inst_valid_id <= 1'b0;
    end else if (clk_en) begin
      if (branch_taken) begin
        inst_id       <= NOP_INST;
        inst_valid_id <= 1'b0;
      end else if (!stall) begin
        if (!fifo_empty) begin
          inst_id       <= fifo_head.inst;
          pc_id         <= fifo_head.pc;
          inst_valid_id <= 1'b1;
        end else begin
          inst_id       <= NOP_INST;
          inst_valid_id <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic against a queue-based model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        inst_valid_id;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jump_addr      (jump_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_id        (inst_id),
    .pc_id          (pc_id),
    .inst_valid_id  (inst_valid_id)
  );

  // Model: requests in flight (address + wrong-path mark), buffered words, decode outputs
  typedef struct { logic [31:0] addr; logic killed; } fly_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  fly_t  m_fly[$];
  pend_t pend_q[$];
  ent_t  m_fifo[$];
  logic [31:0] m_pc, m_inst, m_pcid;
  logic        m_valid;
  int cyc = 0, last_due = 0, lat = 1, total = 0, bad = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_fly.delete();
    pend_q.delete();
    m_fifo.delete();
    m_pc     = 32'h0;
    m_inst   = NOP_INST;
    m_pcid   = 32'h0;
    m_valid  = 1'b0;
    last_due = cyc;
  endtask

  task automatic check_outputs();
    chk("inst_id", inst_id, m_inst);
    chk("pc_id", pc_id, m_pcid);
    chk("inst_valid_id", {31'b0, inst_valid_id}, {31'b0, m_valid});
  endtask

  task automatic model_update(input logic rq);
    ent_t  e;
    fly_t  f;
    pend_t p;
    // Decode side sees only what was buffered before this edge
    if (clk_en && branch_taken) begin
      m_inst  = NOP_INST;
      m_valid = 1'b0;
    end else if (clk_en && !stall) begin
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_inst = e.inst; m_pcid = e.pc; m_valid = 1'b1;
      end else begin
        m_inst = NOP_INST; m_valid = 1'b0;
      end
    end
    if (imem_rsp_valid) begin
      f = m_fly.pop_front();
      void'(pend_q.pop_front());
      if (!f.killed) m_fifo.push_back('{imem_rsp_data, f.addr});
    end
    if (clk_en && branch_taken) begin
      m_fifo.delete();
      foreach (m_fly[i]) m_fly[i].killed = 1'b1;
      m_pc = {jump_addr[31:2], 2'b00};
    end
    if (rq && imem_gnt) begin
      m_fly.push_back('{m_pc, 1'b0});
      p.addr = m_pc;
      p.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = p.due;
      pend_q.push_back(p);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    logic exp_req;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    exp_req = clk_en && !branch_taken && (m_fly.size() < MAXO) &&
              (m_fifo.size() + m_fly.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_pc);
    model_update(exp_req);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    imem_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_inst", inst_id, NOP_INST);
    chk("rst_pc", pc_id, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_id}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b0;

    // Streaming with single-cycle memory
    imem_gnt = 1'b1; lat = 1;
    repeat (12) step();

    // Stall mid-stream
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (6) step();

    // Redirect with two responses in flight
    lat = 2; n = 0;
    while (m_fly.size() < 2 && n < 20) begin step(); n++; end
    chk("t3_two_in_flight", m_fly.size(), 32'd2);
    branch_taken = 1'b1; jump_addr = 32'h100;
    step();
    chk("t3_bubble", {31'b0, inst_valid_id}, 32'h0);
    branch_taken = 1'b0;
    n = 0;
    while (!inst_valid_id && n < 12) begin step(); n++; end
    chk("t3_first_pc", pc_id, 32'h100);
    repeat (4) step();

    // Grant held low, then slow responses
    imem_gnt = 1'b0; lat = 3;
    repeat (5) step();
    imem_gnt = 1'b1;
    repeat (10) step();

    // clk_en low while a response lands
    lat = 2; n = 0;
    while (m_fly.size() == 0 && n < 10) begin step(); n++; end
    clk_en = 1'b0;
    repeat (4) step();
    clk_en = 1'b1;
    repeat (6) step();

    // Misaligned target near the top of the address space: wraps to 0
    lat = 1;
    branch_taken = 1'b1; jump_addr = 32'hFFFF_FFF6;
    step();
    branch_taken = 1'b0;
    repeat (8) step();

    // Reset mid-stream
    do_reset();
    repeat (6) step();

    // Random traffic
    repeat (400) begin
      clk_en       = ($urandom_range(0, 9) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      jump_addr    = $urandom;
      imem_gnt     = ($urandom_range(0, 3) != 0);
      lat          = $urandom_range(1, 3);
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
